// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache line refill controller.
package icache_pkg;

  localparam int unsigned DEF_LINE_WORDS  = 4;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  localparam int unsigned OFFSET_BITS = $clog2(DEF_LINE_WORDS * 4);
  localparam int unsigned IDX_BITS    = $clog2(DEF_LINE_WORDS);

  // Widest address the helpers accept; callers cast to their own width.
  localparam int unsigned ADDR_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    DONE,
    ERR
  } refill_state_t;

  // Clear the byte-offset-within-line bits of an address.
  function automatic logic [ADDR_MAX_W-1:0] line_base(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int unsigned off_bits);
    logic [ADDR_MAX_W-1:0] mask;
    mask = (ADDR_MAX_W'(1) << off_bits) - ADDR_MAX_W'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refills one I-cache line from backing memory, critical word first with wrap,
// one outstanding request at a time, aborting on bus error or response timeout.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              miss_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              refill_valid,
  output logic [ADDR_W-1:0] refill_address,
  output logic [31:0]       refill_data,
  output logic              refill_done,
  output logic              refill_error
);

  localparam int unsigned off_bits  = $clog2(LINE_WORDS * 4);
  localparam int unsigned idx_bits  = $clog2(LINE_WORDS);
  localparam int unsigned beat_bits = $clog2(LINE_WORDS + 1);
  localparam int unsigned tmo_bits  = $clog2(TIMEOUT_CYC + 1);

  refill_state_t        state, state_n;
  logic [ADDR_W-1:0]    base, base_n;
  logic [idx_bits-1:0]  idx, idx_n;
  logic [beat_bits-1:0] beats, beats_n;
  logic [tmo_bits-1:0]  tcnt, tcnt_n;
  logic [ADDR_W-1:0]    raddr_n;
  logic [31:0]          rdata_n;

  // Base has its offset bits clear, so OR-ing in the word offset never carries.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [idx_bits-1:0] i);
    return b | ADDR_W'({i, 2'b00});
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    base_n  = base;
    idx_n   = idx;
    beats_n = beats;
    tcnt_n  = tcnt;
    raddr_n = refill_address;
    rdata_n = refill_data;
    case (state)
      IDLE: begin
        if (miss_valid && miss_ready) begin
          state_n = REQ;
          base_n  = ADDR_W'(line_base(ADDR_MAX_W'(miss_address), off_bits));
          idx_n   = miss_address[off_bits-1:2];
          beats_n = '0;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_n = WAIT;
          tcnt_n  = '0;
        end
      end
      WAIT: begin
        // A response on the expiry cycle takes priority over the timeout.
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            state_n = ERR;
          end else begin
            state_n = WRITE;
            rdata_n = mem_rsp_data;
            raddr_n = word_addr(base, idx);
          end
        end else if (tcnt == tmo_bits'(TIMEOUT_CYC - 1)) begin
          state_n = ERR;
        end else begin
          tcnt_n = tcnt + tmo_bits'(1);
        end
      end
      WRITE: begin
        idx_n   = idx + idx_bits'(1);
        beats_n = beats + beat_bits'(1);
        state_n = (beats == beat_bits'(LINE_WORDS - 1)) ? DONE : REQ;
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base  <= '0;
      idx   <= '0;
      beats <= '0;
      tcnt  <= '0;
    end else begin
      base  <= base_n;
      idx   <= idx_n;
      beats <= beats_n;
      tcnt  <= tcnt_n;
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_ready     <= 1'b1;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      refill_valid   <= 1'b0;
      refill_address <= '0;
      refill_data    <= '0;
      refill_done    <= 1'b0;
      refill_error   <= 1'b0;
    end else begin
      miss_ready     <= (state_n == IDLE);
      mem_req_valid  <= (state_n == REQ);
      if (state_n == REQ) begin
        mem_req_addr <= word_addr(base_n, idx_n);
      end
      refill_valid   <= (state_n == WRITE);
      refill_address <= raddr_n;
      refill_data    <= rdata_n;
      refill_done    <= (state_n == DONE);
      refill_error   <= (state_n == ERR);
    end
  end

endmodule
